// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MEM stage vs aux port, with anti-starvation
// and fixed-latency read-data routing back to the issuing requester.
module dmem_arbiter #(
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_cmd,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_rsp_vld,
  output logic [31:0] mem_rsp_data,
  input  logic [1:0]  aux_cmd,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_din,
  output logic        aux_gnt,
  output logic        aux_rsp_vld,
  output logic [31:0] aux_rsp_data,
  output logic [1:0]  DM_mem_cmd,
  output logic [31:0] DM_mem_addr,
  output logic [31:0] DM_mem_din,
  input  logic [31:0] DM_mem_dout
);

  typedef enum logic {PRI_MEM, PRI_AUX} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        mem_act, aux_act;
  logic        mem_win, aux_win;
  logic        load_issue;
  logic        rsp_vld;
  logic [RD_LAT-1:0] vld_q, own_q;

  assign mem_act = (mem_cmd == 2'b01) || (mem_cmd == 2'b10);
  assign aux_act = (aux_cmd == 2'b01) || (aux_cmd == 2'b10);

  always_comb begin
    mem_win  = 1'b0;
    aux_win  = 1'b0;
    state_d  = PRI_MEM;
    starve_d = starve_q;
    if (!rst) begin
      aux_win = aux_act && (!mem_act || state_q == PRI_AUX);
      mem_win = mem_act && !aux_win;
    end
    // only a contested loss in PRI_MEM can reach the else branch
    if (aux_win || !aux_act) begin
      starve_d = 4'd0;
    end else begin
      starve_d = starve_q + 4'd1;
      if (starve_d == 4'(STARVE_LIMIT))
        state_d = PRI_AUX;
    end
  end

  always_comb begin
    DM_mem_cmd  = 2'b00;
    DM_mem_addr = 32'd0;
    DM_mem_din  = 32'd0;
    unique case (1'b1)
      mem_win: begin
        DM_mem_cmd  = mem_cmd;
        DM_mem_addr = mem_addr;
        DM_mem_din  = mem_din;
      end
      aux_win: begin
        DM_mem_cmd  = aux_cmd;
        DM_mem_addr = aux_addr;
        DM_mem_din  = aux_din;
      end
      default: ;
    endcase
  end

  assign mem_stall  = mem_act && !mem_win && !rst;
  assign aux_gnt    = aux_win;
  assign load_issue = (mem_win && mem_cmd == 2'b01) ||
                      (aux_win && aux_cmd == 2'b01);

  assign rsp_vld      = vld_q[RD_LAT-1] && !rst;
  assign mem_rsp_vld  = rsp_vld && !own_q[RD_LAT-1];
  assign aux_rsp_vld  = rsp_vld && own_q[RD_LAT-1];
  assign mem_rsp_data = mem_rsp_vld ? DM_mem_dout : 32'd0;
  assign aux_rsp_data = aux_rsp_vld ? DM_mem_dout : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PRI_MEM;
      starve_q <= 4'd0;
      vld_q    <= '0;
      own_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      vld_q[0] <= load_issue;
      own_q[0] <= aux_win;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural model compared every cycle,
// directed scenarios with literal checks, then randomized traffic.
module tb_dmem_arbiter;
  localparam int RD_LAT = 2;
  localparam int LIMIT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mem_cmd = 2'b00, aux_cmd = 2'b00;
  logic [31:0] mem_addr = 0, mem_din = 0;
  logic [31:0] aux_addr = 0, aux_din = 0;
  logic [31:0] dout = 0;
  logic        mem_stall, mem_rsp_vld, aux_gnt, aux_rsp_vld;
  logic [31:0] mem_rsp_data, aux_rsp_data;
  logic [1:0]  dm_cmd;
  logic [31:0] dm_addr, dm_din;

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.RD_LAT(RD_LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_stall(mem_stall), .mem_rsp_vld(mem_rsp_vld),
    .mem_rsp_data(mem_rsp_data),
    .aux_cmd(aux_cmd), .aux_addr(aux_addr), .aux_din(aux_din),
    .aux_gnt(aux_gnt), .aux_rsp_vld(aux_rsp_vld),
    .aux_rsp_data(aux_rsp_data),
    .DM_mem_cmd(dm_cmd), .DM_mem_addr(dm_addr), .DM_mem_din(dm_din),
    .DM_mem_dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Model: requests ranked by the current priority; outstanding
  // loads are kept as a map from due cycle to owner (1 = aux).
  int  cyc = 0;
  int  losses = 0;
  bit  forced = 0;
  bit  due_own[int];

  function automatic bit is_act(input logic [1:0] c);
    return c == 2'b01 || c == 2'b10;
  endfunction

  always @(negedge clk) begin
    bit ma, aa, aw, mw, rv, ro;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr, e_din;
    ma = is_act(mem_cmd);
    aa = is_act(aux_cmd);
    if (rst) begin
      chk("rst_cmd", 32'(dm_cmd), 0);
      chk("rst_addr", dm_addr, 0);
      chk("rst_din", dm_din, 0);
      chk("rst_stall", 32'(mem_stall), 0);
      chk("rst_gnt", 32'(aux_gnt), 0);
      chk("rst_mrsp", {31'd0, mem_rsp_vld}, 0);
      chk("rst_arsp", {31'd0, aux_rsp_vld}, 0);
      chk("rst_mdat", mem_rsp_data, 0);
      chk("rst_adat", aux_rsp_data, 0);
      due_own.delete();
      losses = 0;
      forced = 0;
    end else begin
      aw = aa && (!ma || forced);
      mw = ma && !aw;
      e_cmd = 2'b00; e_addr = 0; e_din = 0;
      if (mw) begin e_cmd = mem_cmd; e_addr = mem_addr; e_din = mem_din; end
      if (aw) begin e_cmd = aux_cmd; e_addr = aux_addr; e_din = aux_din; end
      rv = due_own.exists(cyc);
      ro = rv ? due_own[cyc] : 1'b0;
      chk("dm_cmd", 32'(dm_cmd), 32'(e_cmd));
      chk("dm_addr", dm_addr, e_addr);
      chk("dm_din", dm_din, e_din);
      chk("stall", 32'(mem_stall), 32'(ma && !mw));
      chk("gnt", 32'(aux_gnt), 32'(aw));
      chk("mrsp_vld", 32'(mem_rsp_vld), 32'(rv && !ro));
      chk("arsp_vld", 32'(aux_rsp_vld), 32'(rv && ro));
      chk("mrsp_dat", mem_rsp_data, (rv && !ro) ? dout : 0);
      chk("arsp_dat", aux_rsp_data, (rv && ro) ? dout : 0);
      if (rv) due_own.delete(cyc);
      if (e_cmd == 2'b01) due_own[cyc + RD_LAT] = aw;
      if (forced || aw || !aa) begin
        forced = 0;
        losses = 0;
      end else begin
        losses++;
        if (losses == LIMIT) forced = 1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] mc, input logic [31:0] ma,
                     input logic [1:0] ac, input logic [31:0] aa,
                     input logic [31:0] d);
    mem_cmd = mc; mem_addr = ma; mem_din = ma ^ 32'h5555_0000;
    aux_cmd = ac; aux_addr = aa; aux_din = aa ^ 32'h0000_AAAA;
    dout = d;
  endtask

  initial begin
    bit apend;
    logic [31:0] d2, d3, d4;
    repeat (2) tick();
    rst = 0;
    drv(0, 0, 0, 0, 0);
    tick();

    // 1: single MEM load, data returns RD_LAT later
    drv(2'b01, 32'h100, 0, 0, 0);
    #2;
    chk("t1_cmd", 32'(dm_cmd), 1);
    chk("t1_stall", 32'(mem_stall), 0);
    tick(); drv(0, 0, 0, 0, 0);
    tick(); drv(0, 0, 0, 0, 32'hDEADBEEF);
    #2;
    chk("t1_vld", 32'(mem_rsp_vld), 1);
    chk("t1_data", mem_rsp_data, 32'hDEADBEEF);
    chk("t1_aux", 32'(aux_rsp_vld), 0);

    // 2: continuous contention
    for (int i = 0; i < 6; i++) begin
      tick(); drv(2'b01, 32'h40 + i, 2'b10, 32'h200, $urandom);
      #2;
      chk("t2_gnt", 32'(aux_gnt), (i == 4) ? 1 : 0);
      chk("t2_stall", 32'(mem_stall), (i == 4) ? 1 : 0);
    end
    repeat (3) begin tick(); drv(0, 0, 0, 0, 0); end

    // 3: interleaved loads
    d2 = 32'h1111_0030; d3 = 32'h2222_0020; d4 = 32'h3333_0030;
    tick(); drv(2'b01, 32'h10, 0, 0, 0);
    tick(); drv(0, 0, 2'b01, 32'h20, 0);
    tick(); drv(2'b01, 32'h30, 0, 0, d2);
    #2;
    chk("t3_m0", mem_rsp_data, d2);
    tick(); drv(0, 0, 0, 0, d3);
    #2;
    chk("t3_a1", aux_rsp_data, d3);
    chk("t3_a1v", 32'(mem_rsp_vld), 0);
    tick(); drv(0, 0, 0, 0, d4);
    #2;
    chk("t3_m2", mem_rsp_data, d4);

    // 4: reserved command is idle
    tick(); drv(2'b11, 32'hABC, 2'b00, 32'h123, 0);
    #2;
    chk("t4_cmd", 32'(dm_cmd), 0);
    chk("t4_addr", dm_addr, 0);
    chk("t4_stall", 32'(mem_stall), 0);
    repeat (2) begin tick(); drv(0, 0, 0, 0, 0); end

    // 5: reset kills in-flight load and the starvation count
    repeat (2) begin tick(); drv(2'b10, 32'h8, 2'b10, 32'h9, 0); end
    tick(); drv(2'b01, 32'h8, 2'b10, 32'h9, 0);
    tick(); rst = 1; drv(2'b01, 32'h8, 2'b10, 32'h9, 0);
    #2;
    chk("t5_rcmd", 32'(dm_cmd), 0);
    tick(); rst = 0; drv(2'b10, 32'h8, 2'b10, 32'h9, 32'hFEED);
    #2;
    chk("t5_norsp", 32'(mem_rsp_vld), 0);
    chk("t5_gnt0", 32'(aux_gnt), 0);
    for (int i = 1; i < 5; i++) begin
      tick(); drv(2'b10, 32'h8, 2'b10, 32'h9, 0);
      #2;
      chk("t5_gnt", 32'(aux_gnt), (i == 4) ? 1 : 0);
    end
    repeat (2) begin tick(); drv(0, 0, 0, 0, 0); end

    // 6: aux abandons in its forced cycle
    repeat (4) begin tick(); drv(2'b10, 32'h4, 2'b10, 32'h5, 0); end
    tick(); drv(2'b01, 32'h4, 2'b00, 0, 0);
    #2;
    chk("t6_stall", 32'(mem_stall), 0);
    chk("t6_cmd", 32'(dm_cmd), 1);
    tick(); drv(2'b10, 32'h4, 2'b10, 32'h5, 0);
    #2;
    chk("t6_back", 32'(aux_gnt), 0);

    // random traffic; aux holds its request until granted or dropped
    apend = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      mem_cmd = 2'($urandom);
      mem_addr = $urandom; mem_din = $urandom;
      dout = $urandom;
      if (!apend || $urandom_range(0, 7) == 0) begin
        aux_cmd = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
        aux_addr = $urandom; aux_din = $urandom;
      end
      #2;
      apend = is_act(aux_cmd) && !aux_gnt && !rst;
    end
    tick(); rst = 0; drv(0, 0, 0, 0, 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
